// File: rtl/dm_mm2s_seq.sv
// dm_mm2s_seq: issues an AXI DataMover MM2S transfer as a stream of
// fixed-size commands and checks every returned status in order.
//
// The transfer is split into chunks of at most CHUNK_BYTES. No more than
// MAX_OUT commands may be waiting for a status at any time. The first bad
// status sets a sticky error. After that the block issues no new commands
// and waits until every outstanding status has come back.
//
// Ports
//   clk_i                    clock, rising edge
//   rst_i                    synchronous reset, active high
//   start_i                  one-cycle request pulse, honoured in IDLE only
//   base_addr_i / total_len_i  byte start address / byte length of transfer
//   busy_o                   high in RUN and DRAIN
//   done_o                   one-cycle completion pulse
//   err_o / err_sts_o        sticky error flag / status byte that caused it
//   m_axis_mm2s_cmd_*        72-bit command stream
//   s_axis_mm2s_sts_*        8-bit status stream (always ready outside reset)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing commands and collecting statuses
// DRAIN | error seen, collecting remaining statuses only

module dm_mm2s_seq #(
    parameter int unsigned CHUNK_BYTES = 4096,
    parameter int unsigned MAX_OUT     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [31:0] total_len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  err_sts_o,
    output logic [71:0] m_axis_mm2s_cmd_tdata_o,
    output logic        m_axis_mm2s_cmd_tvalid_o,
    input  logic        m_axis_mm2s_cmd_tready_i,
    input  logic [7:0]  s_axis_mm2s_sts_tdata_i,
    input  logic        s_axis_mm2s_sts_tvalid_i,
    output logic        s_axis_mm2s_sts_tready_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [22:0] CHUNK_BTT = 23'(CHUNK_BYTES);
    localparam logic [3:0]  MAX_C     = 4'(MAX_OUT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rem_q, rem_d;
    logic [3:0]  tag_q, tag_d;
    logic [3:0]  exp_q, exp_d;
    logic [3:0]  out_q, out_d;
    logic        err_q, err_d;
    logic [7:0]  err_sts_q, err_sts_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [71:0] cmd_data_q, cmd_data_d;
    logic        sts_ready_q;

    logic        cmd_hs, sts_hs, sts_ok, pending, draining;
    logic [22:0] btt_now;

    function automatic logic [22:0] btt_of(input logic [31:0] rem);
        return (rem > {9'd0, CHUNK_BTT}) ? CHUNK_BTT : rem[22:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        tag_d     = tag_q;
        exp_d     = exp_q;
        out_d     = out_q;
        err_d     = err_q;
        err_sts_d = err_sts_q;
        done_d    = 1'b0;
        draining  = 1'b0;

        cmd_hs  = cmd_valid_q & m_axis_mm2s_cmd_tready_i;
        sts_hs  = s_axis_mm2s_sts_tvalid_i & sts_ready_q;
        // An offered command must stay offered until it is taken, even if an
        // error arrives meanwhile.
        pending = cmd_valid_q & ~m_axis_mm2s_cmd_tready_i;
        btt_now = btt_of(rem_q);
        sts_ok  = s_axis_mm2s_sts_tdata_i[7] &&
                  (s_axis_mm2s_sts_tdata_i[6:4] == 3'd0) &&
                  (s_axis_mm2s_sts_tdata_i[3:0] == exp_q);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d    = base_addr_i;
                    rem_d     = total_len_i;
                    tag_d     = 4'd0;
                    exp_d     = 4'd0;
                    out_d     = 4'd0;
                    err_d     = 1'b0;
                    err_sts_d = 8'd0;
                    if (total_len_i == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                if (cmd_hs) begin
                    addr_d = addr_q + {9'd0, btt_now};
                    rem_d  = rem_q - {9'd0, btt_now};
                    tag_d  = tag_q + 4'd1;
                end
                if (cmd_hs && !sts_hs) begin
                    out_d = out_q + 4'd1;
                end else if (!cmd_hs && sts_hs && out_q != 4'd0) begin
                    out_d = out_q - 4'd1;
                end
                if (sts_hs) begin
                    exp_d = exp_q + 4'd1;
                    if (!sts_ok && !err_q) begin
                        err_d     = 1'b1;
                        err_sts_d = s_axis_mm2s_sts_tdata_i;
                    end
                end
                draining = (state_q == S_DRAIN) || (sts_hs && !sts_ok);
                if (!draining) begin
                    if (rem_d == 32'd0 && out_d == 4'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (out_d == 4'd0 && !pending) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
        endcase

        cmd_valid_d = pending ||
                      (state_d == S_RUN && rem_d != 32'd0 && out_d < MAX_C);
        cmd_data_d  = pending ? cmd_data_q :
                      {4'h0, tag_d, addr_d, 1'b0, 1'b1, 6'h0, 1'b1, btt_of(rem_d)};
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            rem_q       <= 32'd0;
            tag_q       <= 4'd0;
            exp_q       <= 4'd0;
            out_q       <= 4'd0;
            err_q       <= 1'b0;
            err_sts_q   <= 8'd0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= 72'd0;
            sts_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            tag_q       <= tag_d;
            exp_q       <= exp_d;
            out_q       <= out_d;
            err_q       <= err_d;
            err_sts_q   <= err_sts_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            sts_ready_q <= 1'b1;
        end
    end

    assign busy_o                   = busy_q;
    assign done_o                   = done_q;
    assign err_o                    = err_q;
    assign err_sts_o                = err_sts_q;
    assign m_axis_mm2s_cmd_tdata_o  = cmd_data_q;
    assign m_axis_mm2s_cmd_tvalid_o = cmd_valid_q;
    assign s_axis_mm2s_sts_tready_o = sts_ready_q;

endmodule
